muldiv_seq: RTL

- Multi-cycle sequencer for the RV32M operations: MUL, DIV, DIVU, REM, REMU.
- Takes these ops out of the single-cycle ALU path so the core does not need a combinational multiplier or divider.
- Sits beside the ALU in the execute stage. The core raises start with operands and the 4-bit ALU op code, stalls while busy, and captures result on the done pulse.
- Uses an iterative shift-add multiplier and a restoring divider, one bit per cycle, under a small FSM.

---
 rtl/muldiv_seq.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/muldiv_seq.sv
// Multi-cycle RV32M MUL/DIV/DIVU/REM/REMU unit: shift-add multiply and restoring divide, one bit per cycle.
// Ports: clk, rst_n, start/op/a/b request, flush abort; ready, busy, done pulse, registered result.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [3:0] OP_MUL  = 4'b1000;
  localparam logic [3:0] OP_DIV  = 4'b1010;
  localparam logic [3:0] OP_DIVU = 4'b1011;
  localparam logic [3:0] OP_REM  = 4'b1100;
  localparam logic [3:0] OP_REMU = 4'b1101;

  localparam logic [WIDTH-1:0] ONES = '1;
  localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             neg_q;
  logic             neg_r;

  // Outputs decode the registered state only.
  assign ready = (state == IDLE);
  assign busy  = (state != IDLE);
  assign done  = (state == DONE);

  // Accept-time decode of the incoming request.
  logic             is_sdiv;
  logic             is_dfam;
  logic             known;
  logic             b_zero;
  logic             ovf;
  logic             special;
  logic [WIDTH-1:0] spec_val;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  always_comb begin
    is_sdiv  = (op == OP_DIV) || (op == OP_REM);
    is_dfam  = is_sdiv || (op == OP_DIVU) || (op == OP_REMU);
    known    = is_dfam || (op == OP_MUL);
    b_zero   = (b == '0);
    ovf      = is_sdiv && (a == MINV) && (b == ONES);
    special  = !known || (is_dfam && (b_zero || ovf));
    a_mag    = (is_sdiv && a[WIDTH-1]) ? -a : a;
    b_mag    = (is_sdiv && b[WIDTH-1]) ? -b : b;
    spec_val = '0;
    if (is_dfam && b_zero) begin
      case (op)
        OP_DIV, OP_DIVU: spec_val = ONES;
        default:         spec_val = a;
      endcase
    end else if (ovf) begin
      spec_val = (op == OP_DIV) ? MINV : '0;
    end
  end

  // One iteration of the running operation.
  // Multiply: acc += x when y[0]; x shifts up, y shifts down.
  // Divide: acc is the partial remainder, x shifts dividend bits out
  // on the left and quotient bits in on the right, y is the divisor.
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] acc_n;
  logic [WIDTH-1:0] x_n;
  logic [WIDTH-1:0] y_n;
  logic [WIDTH-1:0] fin;

  always_comb begin
    rem_sh = {acc, x[WIDTH-1]};
    diff   = rem_sh - {1'b0, y};
    acc_n  = acc;
    x_n    = x;
    y_n    = y;
    if (op_q == OP_MUL) begin
      acc_n = acc + (y[0] ? x : '0);
      x_n   = x << 1;
      y_n   = y >> 1;
    end else if (!diff[WIDTH]) begin
      acc_n = diff[WIDTH-1:0];
      x_n   = {x[WIDTH-2:0], 1'b1};
    end else begin
      acc_n = rem_sh[WIDTH-1:0];
      x_n   = {x[WIDTH-2:0], 1'b0};
    end
  end

  // Sign fix-up applied to the final iteration's outputs.
  always_comb begin
    case (op_q)
      OP_MUL:  fin = acc_n;
      OP_DIV:  fin = neg_q ? -x_n : x_n;
      OP_DIVU: fin = x_n;
      OP_REM:  fin = neg_r ? -acc_n : acc_n;
      OP_REMU: fin = acc_n;
      default: fin = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      op_q   <= '0;
      acc    <= '0;
      x      <= '0;
      y      <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      result <= '0;
    end else if (flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_q  <= op;
            cnt   <= '0;
            acc   <= '0;
            neg_q <= is_sdiv && (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r <= is_sdiv && a[WIDTH-1];
            if (is_dfam) begin
              x <= a_mag;
              y <= b_mag;
            end else begin
              x <= a;
              y <= b;
            end
            if (special) begin
              result <= spec_val;
              state  <= DONE;
            end else begin
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          acc <= acc_n;
          x   <= x_n;
          y   <= y_n;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH-1)) begin
            result <= fin;
            state  <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
